// File: rtl/usart_rx_fifo.sv
// USART receive buffer: synchronises the receiver handshake, stores bytes in a
// first-word-fall-through FIFO, and reports RTS, overrun and framing status.
module usart_rx_fifo #(
   parameter int DEPTH_LOG2    = 4,
   parameter int RTS_THRESHOLD = 12
) (
   input  logic                serial_clock,
   input  logic                reset,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   input  logic                in_error,
   output logic                in_ready,
   output logic [7:0]          out_data,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                clear,
   output logic [DEPTH_LOG2:0] count,
   output logic                overrun,
   output logic [7:0]          framing_errors,
   output logic                rts_out
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2:0] cnt_t;
   typedef enum logic {IDLE, ACK} state_t;

   localparam cnt_t FULL   = cnt_t'(DEPTH);
   localparam cnt_t THRESH = cnt_t'(RTS_THRESHOLD);

   state_t                state;
   state_t                state_nxt;
   logic                  v1, v2, e1, e2;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   cnt_t                  count_nxt;
   logic                  push;
   logic                  err_evt;
   logic                  pop;
   logic                  full;
   logic                  push_ok;

   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         e1 <= 1'b0;
         e2 <= 1'b0;
      end else begin
         v1 <= in_valid;
         v2 <= v1;
         e1 <= in_error;
         e2 <= e1;
      end
   end

   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // One push or error event per handshake, on the IDLE->ACK transition only
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      err_evt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (v2) begin
               push      = 1'b1;
               state_nxt = ACK;
            end else if (e2) begin
               err_evt   = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            if (!v2 && !e2) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == ACK);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign full      = (count == FULL);
   assign pop       = out_valid && out_ready;
   assign push_ok   = push && (!full || pop);

   always_comb begin
      count_nxt = count;
      if (clear)                 count_nxt = '0;
      else if (push_ok && !pop)  count_nxt = count + cnt_t'(1);
      else if (!push_ok && pop)  count_nxt = count - cnt_t'(1);
   end

   always_ff @(posedge serial_clock) begin
      if (push_ok && !clear) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge serial_clock or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overrun        <= 1'b0;
         framing_errors <= 8'd0;
         rts_out        <= 1'b1;
      end else begin
         count   <= count_nxt;
         rts_out <= (count_nxt >= THRESH);
         if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overrun        <= 1'b0;
            framing_errors <= 8'd0;
         end else begin
            if (push_ok)           wr_ptr  <= wr_ptr + 1'b1;
            if (pop)               rd_ptr  <= rd_ptr + 1'b1;
            if (push && !push_ok)  overrun <= 1'b1;
            if (err_evt && framing_errors != 8'hFF)
               framing_errors <= framing_errors + 8'd1;
         end
      end
   end

endmodule
